varredura_matriz_pisca: RTL and testbench

Multiplexed scan driver for the 5-column × 7-row LED matrix of the battleship board. It sits directly downstream of the game controller and consumes the five 7-bit column images (`coluna1`..`coluna5`) that the controller produces. Per-cell blink masks let hits and the attack cursor flash. It drives the physical `colunas`/`linhas` pins with tear-free, frame-coherent scanning and a configurable blanking gap against ghosting.

---
 rtl/varredura_matriz_pisca.sv | 102 ++++++++++
 tb/tb_varredura_matriz_pisca.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/varredura_matriz_pisca.sv
// Multiplexed 5x7 LED matrix scan driver with per-frame input snapshot,
// per-cell blink masks and an optional blanking cycle at the start of each column slot.
module varredura_matriz_pisca #(
  parameter int CICLOS_COLUNA = 2,
  parameter bit APAGAR        = 1'b1,
  parameter int QUADROS_PISCA = 19
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] coluna1,
  input  logic [6:0] coluna2,
  input  logic [6:0] coluna3,
  input  logic [6:0] coluna4,
  input  logic [6:0] coluna5,
  input  logic [6:0] pisca1,
  input  logic [6:0] pisca2,
  input  logic [6:0] pisca3,
  input  logic [6:0] pisca4,
  input  logic [6:0] pisca5,
  output logic [4:0] colunas,
  output logic [6:0] linhas,
  output logic       fim_quadro
);
  localparam int KW = (CICLOS_COLUNA > 1) ? $clog2(CICLOS_COLUNA) : 1;
  localparam int QW = (QUADROS_PISCA > 1) ? $clog2(QUADROS_PISCA) : 1;
  localparam logic [KW-1:0] K_ULT = KW'(CICLOS_COLUNA - 1);
  localparam logic [QW-1:0] Q_ULT = QW'(QUADROS_PISCA - 1);

  logic [2:0]      col_i, col_i_nxt;
  logic [KW-1:0]   slot_k, slot_k_nxt;
  logic [QW-1:0]   quadro_q, quadro_q_nxt;
  logic            fase, fase_nxt;
  logic            entra;
  logic [4:0][6:0] img, msk;
  logic [4:0][6:0] sh_img, sh_msk, sh_img_nxt, sh_msk_nxt;
  logic [4:0]      colunas_nxt;
  logic [6:0]      linhas_nxt;
  logic            fim_nxt;

  assign img   = {coluna5, coluna4, coluna3, coluna2, coluna1};
  assign msk   = {pisca5, pisca4, pisca3, pisca2, pisca1};
  // the edge leaving the last slot is the edge that starts a new frame
  assign entra = (col_i == 3'd4) && (slot_k == K_ULT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_i      <= 3'd4;
      slot_k     <= K_ULT;
      quadro_q   <= '0;
      fase       <= 1'b0;
      sh_img     <= '0;
      sh_msk     <= '0;
      colunas    <= 5'h1F;
      linhas     <= '0;
      fim_quadro <= 1'b0;
    end else begin
      col_i      <= col_i_nxt;
      slot_k     <= slot_k_nxt;
      quadro_q   <= quadro_q_nxt;
      fase       <= fase_nxt;
      sh_img     <= sh_img_nxt;
      sh_msk     <= sh_msk_nxt;
      colunas    <= colunas_nxt;
      linhas     <= linhas_nxt;
      fim_quadro <= fim_nxt;
    end
  end

  always_comb begin
    col_i_nxt    = col_i;
    slot_k_nxt   = slot_k + 1'b1;
    quadro_q_nxt = quadro_q;
    fase_nxt     = fase;
    sh_img_nxt   = sh_img;
    sh_msk_nxt   = sh_msk;
    if (slot_k == K_ULT) begin
      slot_k_nxt = '0;
      col_i_nxt  = (col_i == 3'd4) ? 3'd0 : col_i + 3'd1;
    end
    if (entra) begin
      sh_img_nxt = img;
      sh_msk_nxt = msk;
      if (quadro_q == Q_ULT) begin
        quadro_q_nxt = '0;
        fase_nxt     = ~fase;
      end else begin
        quadro_q_nxt = quadro_q + 1'b1;
      end
    end
  end

  // outputs decode the state being entered so they stay registered with no lag
  always_comb begin
    colunas_nxt = ~(5'b00001 << col_i_nxt);
    linhas_nxt  = sh_img_nxt[col_i_nxt] & ~(sh_msk_nxt[col_i_nxt] & {7{fase_nxt}});
    fim_nxt     = (col_i_nxt == 3'd4) && (slot_k_nxt == K_ULT);
    if (APAGAR && (slot_k_nxt == '0)) begin
      colunas_nxt = 5'h1F;
      linhas_nxt  = '0;
    end
  end
endmodule

// File: tb/tb_varredura_matriz_pisca.sv
// Bench: two scan driver configurations checked every cycle against a frame-arithmetic model.
module tb_varredura_matriz_pisca;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] col [5];
  logic [6:0] pis [5];
  logic [4:0] ca, cb;
  logic [6:0] la, lb;
  logic       fa, fb;

  int errors = 0;
  int checks = 0;
  int t = 0;
  logic [6:0] sc [2][5];
  logic [6:0] sp [2][5];

  always #5 clock = ~clock;

  varredura_matriz_pisca #(.CICLOS_COLUNA(1), .APAGAR(1'b0), .QUADROS_PISCA(1)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .coluna1(col[0]), .coluna2(col[1]), .coluna3(col[2]), .coluna4(col[3]), .coluna5(col[4]),
    .pisca1(pis[0]), .pisca2(pis[1]), .pisca3(pis[2]), .pisca4(pis[3]), .pisca5(pis[4]),
    .colunas(ca), .linhas(la), .fim_quadro(fa));

  varredura_matriz_pisca #(.CICLOS_COLUNA(2), .APAGAR(1'b1), .QUADROS_PISCA(2)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .coluna1(col[0]), .coluna2(col[1]), .coluna3(col[2]), .coluna4(col[3]), .coluna5(col[4]),
    .pisca1(pis[0]), .pisca2(pis[1]), .pisca3(pis[2]), .pisca4(pis[3]), .pisca5(pis[4]),
    .colunas(cb), .linhas(lb), .fim_quadro(fb));

  function automatic int pc(input int m); return (m == 0) ? 1 : 2; endfunction
  function automatic int pa(input int m); return (m == 0) ? 0 : 1; endfunction
  function automatic int pq(input int m); return (m == 0) ? 1 : 2; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0h want %0h", nm, t, act, exp);
    end
  endtask

  // Expected outputs from cycle count since release: frame = cycles / frame length.
  task automatic model(input int m, output logic [4:0] ec, output logic [6:0] el, output logic ef);
    int fl, pos, f, i, k, fase;
    ec = 5'h1F; el = '0; ef = 1'b0;
    if (t == 0) return;
    fl   = 5 * pc(m);
    pos  = (t - 1) % fl;
    f    = (t - 1) / fl;
    i    = pos / pc(m);
    k    = pos % pc(m);
    fase = ((f + 1) / pq(m)) % 2;
    ef   = (pos == fl - 1);
    if (pa(m) == 1 && k == 0) return;
    ec = 5'h1F ^ (5'd1 << i);
    el = sc[m][i] & ~((fase == 1) ? sp[m][i] : 7'h00);
  endtask

  initial forever begin
    logic [4:0] ec;
    logic [6:0] el;
    logic       ef;
    @(posedge clock or negedge reset_n);
    if (!reset_n) t = 0;
    else begin
      t++;
      for (int m = 0; m < 2; m++)
        if ((t - 1) % (5 * pc(m)) == 0)
          for (int j = 0; j < 5; j++) begin sc[m][j] = col[j]; sp[m][j] = pis[j]; end
    end
    #1;
    model(0, ec, el, ef);
    chk("a_colunas", ca, ec); chk("a_linhas", la, el); chk("a_fim", fa, ef);
    model(1, ec, el, ef);
    chk("b_colunas", cb, ec); chk("b_linhas", lb, el); chk("b_fim", fb, ef);
  end

  initial begin
    logic [4:0] lit_c [5];
    logic [6:0] blink [4];
    int target;
    lit_c[0] = 5'b11110; lit_c[1] = 5'b11101; lit_c[2] = 5'b11011;
    lit_c[3] = 5'b10111; lit_c[4] = 5'b01111;
    blink[0] = 7'h7F; blink[1] = 7'h78; blink[2] = 7'h78; blink[3] = 7'h7F;
    for (int j = 0; j < 5; j++) begin col[j] = 7'h7F; pis[j] = 7'h7F; end
    repeat (3) @(negedge clock);
    chk("rst_colunas", ca, 5'h1F); chk("rst_linhas", la, 7'h00); chk("rst_fim", fa, 1'b0);

    // static scan
    for (int j = 0; j < 5; j++) begin col[j] = 7'(j + 1); pis[j] = 7'h00; end
    @(negedge clock) reset_n = 1'b1;
    for (int p = 0; p < 5; p++) begin
      @(posedge clock); #2;
      chk("static_colunas", ca, lit_c[p]);
      chk("static_linhas", la, 7'(p + 1));
      chk("static_fim", fa, p == 4);
      if (p == 0) begin chk("blank_colunas", cb, 5'h1F); chk("blank_linhas", lb, 7'h00); end
      if (p == 1) begin chk("b_col1", cb, 5'b11110); chk("b_lin1", lb, 7'h01); end
    end

    // snapshot coherence: coluna3 changes while column 2 is displayed
    @(negedge clock) col[2] = 7'h7F;
    @(negedge clock);
    @(negedge clock) col[2] = 7'h00;
    @(posedge clock); #2;
    chk("snap_old", la, 7'h7F);
    repeat (5) @(posedge clock); #2;
    chk("snap_new", la, 7'h00);

    // blink with Q=2 on the blanking instance
    @(negedge clock) begin reset_n = 1'b0; col[0] = 7'h7F; pis[0] = 7'h07; end
    @(negedge clock) reset_n = 1'b1;
    for (int f = 0; f < 4; f++) begin
      target = 10 * f + 2;
      for (int n = 0; n < 50 && t < target; n++) begin @(posedge clock); #2; end
      chk("blink_col1", lb, blink[f]);
    end

    // reset while column 4 is shown
    for (int n = 0; n < 20 && !(t > 0 && (t - 1) % 5 == 3); n++) @(negedge clock);
    chk("align_col4", ca, 5'b10111);
    reset_n = 1'b0;
    #1;
    chk("midrst_colunas", ca, 5'h1F); chk("midrst_linhas", la, 7'h00); chk("midrst_fim", fa, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #2;
    chk("restart_a_col", ca, 5'b11110); chk("restart_a_lin", la, 7'h78);
    @(posedge clock); #2;
    chk("restart_b_col", cb, 5'b11110); chk("restart_b_lin", lb, 7'h7F);

    // randomized inputs with occasional resets
    for (int n = 0; n < 1500; n++) begin
      @(negedge clock);
      reset_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) col[$urandom_range(0, 4)] = 7'($urandom);
      if ($urandom_range(0, 5) == 0) pis[$urandom_range(0, 4)] = 7'($urandom);
    end
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
